// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: round-robin arbiter with a bounded per-requester hold on the shared port.
// Define ARB_STATS_EN to build the stat_conflicts contention counter; otherwise it reads 0.
module rr_hold_arbiter #(
    parameter int NUM_CORES = 16,
    parameter int MAX_HOLD  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            request,
    input  logic [NUM_CORES-1:0]            hold,
    output logic [NUM_CORES-1:0]            grant_oh,
    output logic [$clog2(NUM_CORES)-1:0]    grant_id,
    output logic                            grant_valid,
    output logic [$clog2(MAX_HOLD+1)-1:0]   hold_cnt,
    output logic [15:0]                     stat_conflicts
);
    localparam int IW = $clog2(NUM_CORES);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t               state, state_n;
    logic [IW-1:0]        ptr, ptr_n, grant_id_n, win_id, idx;
    logic [NUM_CORES-1:0] grant_oh_n, others;
    logic [HW-1:0]        hold_cnt_n;
    logic                 found, keep;

    assign others      = request & ~grant_oh;
    assign grant_valid = |grant_oh;
    // The hold limit only bites when someone else is waiting.
    assign keep = state == OWNED && request[grant_id] && hold[grant_id] &&
                  (hold_cnt < HW'(MAX_HOLD) || others == '0);

    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = IW'((int'(ptr) + i) % NUM_CORES);
            if (!found && request[idx]) begin
                found  = 1'b1;
                win_id = idx;
            end
        end
    end

    always_comb begin
        state_n    = IDLE;
        grant_oh_n = '0;
        grant_id_n = '0;
        hold_cnt_n = '0;
        ptr_n      = ptr;
        if (keep) begin
            state_n    = OWNED;
            grant_oh_n = grant_oh;
            grant_id_n = grant_id;
            hold_cnt_n = hold_cnt < HW'(MAX_HOLD) ? hold_cnt + 1'b1 : hold_cnt;
        end else if (found) begin
            state_n    = OWNED;
            grant_oh_n = NUM_CORES'(1) << win_id;
            grant_id_n = win_id;
            hold_cnt_n = HW'(1);
            ptr_n      = win_id == IW'(NUM_CORES - 1) ? '0 : win_id + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_oh <= '0;
            grant_id <= '0;
            hold_cnt <= '0;
            ptr      <= '0;
        end else begin
            state    <= state_n;
            grant_oh <= grant_oh_n;
            grant_id <= grant_id_n;
            hold_cnt <= hold_cnt_n;
            ptr      <= ptr_n;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stat_conflicts <= '0;
        else if (state == OWNED && others != '0 && stat_conflicts != 16'hFFFF)
            stat_conflicts <= stat_conflicts + 16'd1;
    end
`else
    assign stat_conflicts = '0;
`endif

    assert property (@(posedge clk) disable iff (reset)
        $onehot0(grant_oh) && grant_valid == |grant_oh);

endmodule
